// File: rtl/and_reduce_sequencer_if.sv
// Start/busy/done handshake bundle for and_reduce_sequencer.
// The master drives the request; the slave (the sequencer) reports progress and results.
interface and_reduce_sequencer_if #(
  parameter int N     = 3,
  parameter int CNT_W = 4
);
  logic             start;
  logic [N-1:0]     din;
  logic             busy;
  logic             done;
  logic             result;
  logic [CNT_W-1:0] ops;

  modport master (
    output start, din,
    input  busy, done, result, ops
  );

  modport slave (
    input  start, din,
    output busy, done, result, ops
  );
endinterface

// File: rtl/and_reduce_sequencer.sv
// AND-reduction of an N-bit word using one shared 2-input and_gate,
// consuming one operand bit per clock under a small IDLE/RUN/DONE FSM.
module and_gate (
  output logic out,
  input  logic a,
  input  logic b
);
  assign out = a & b;
endmodule

module and_reduce_sequencer #(
  parameter int N          = 3,
  parameter int EARLY_EXIT = 0,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  and_reduce_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     opreg_q, opreg_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic             gate_b;
  logic             gate_out;

  // Mux by comparison so idx never indexes past opreg (idx can sit at 1 when N==1).
  always_comb begin
    gate_b = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == CNT_W'(i)) begin
        gate_b = opreg_q[i];
      end
    end
  end

  and_gate u_and_gate (
    .out (gate_out),
    .a   (acc_q),
    .b   (gate_b)
  );

  always_comb begin
    state_d = state_q;
    opreg_d = opreg_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    ops_d   = ops_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          opreg_d = bus.din;
          acc_d   = bus.din[0];
          idx_d   = CNT_W'(1);
          ops_d   = '0;
          if ((N == 1) || ((EARLY_EXIT != 0) && !bus.din[0])) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = gate_out;
        idx_d = idx_q + CNT_W'(1);
        ops_d = ops_q + CNT_W'(1);
        if (idx_q == CNT_W'(N - 1)) begin
          state_d = DONE;
        end else if ((EARLY_EXIT != 0) && !gate_out) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opreg_q <= '0;
      acc_q   <= 1'b0;
      idx_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      opreg_q <= opreg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ops_q   <= ops_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = acc_q;
  assign bus.ops    = ops_q;
endmodule

// File: tb/tb_and_reduce_sequencer.sv
// Self-checking bench: three sequencer configurations checked against a
// bit-level reference model of the AND-reduction and its operation count.
module tb_and_reduce_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_s [3];
  logic [6:0] din_s   [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic       res_o   [3];
  logic [3:0] ops_o   [3];

  int n_checks = 0;
  int n_fail   = 0;

  and_reduce_sequencer_if #(.N(3), .CNT_W(4)) if0 ();
  and_reduce_sequencer_if #(.N(3), .CNT_W(4)) if1 ();
  and_reduce_sequencer_if #(.N(7), .CNT_W(3)) if2 ();

  and_reduce_sequencer #(.N(3), .EARLY_EXIT(0), .CNT_W(4)) u0 (.clk(clk), .rst(rst), .bus(if0));
  and_reduce_sequencer #(.N(3), .EARLY_EXIT(1), .CNT_W(4)) u1 (.clk(clk), .rst(rst), .bus(if1));
  and_reduce_sequencer #(.N(7), .EARLY_EXIT(1), .CNT_W(3)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.start = start_s[0];
  assign if1.start = start_s[1];
  assign if2.start = start_s[2];
  assign if0.din   = din_s[0][2:0];
  assign if1.din   = din_s[1][2:0];
  assign if2.din   = din_s[2];
  assign busy_o[0] = if0.busy;
  assign busy_o[1] = if1.busy;
  assign busy_o[2] = if2.busy;
  assign done_o[0] = if0.done;
  assign done_o[1] = if1.done;
  assign done_o[2] = if2.done;
  assign res_o[0]  = if0.result;
  assign res_o[1]  = if1.result;
  assign res_o[2]  = if2.result;
  assign ops_o[0]  = if0.ops;
  assign ops_o[1]  = if1.ops;
  assign ops_o[2]  = {1'b0, if2.ops};

  function automatic int n_of(input int k);
    return (k == 2) ? 7 : 3;
  endfunction

  function automatic int ee_of(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  // Reference: result is 1 iff every operand bit is 1; the cost is n-1
  // operations, or the position of the first 0 when early exit is on.
  function automatic void model(input int n, input int ee, input logic [6:0] d,
                                output logic r, output int ops);
    int first_zero;
    r = 1'b1;
    first_zero = -1;
    for (int i = 0; i < n; i++) begin
      if (d[i] == 1'b0) begin
        r = 1'b0;
        if (first_zero < 0) first_zero = i;
      end
    end
    ops = (ee != 0 && first_zero >= 0) ? first_zero : n - 1;
  endfunction

  task automatic run_one(input int k, input logic [6:0] d, input string tag);
    logic er;
    int   eo;
    model(n_of(k), ee_of(k), d, er, eo);
    @(negedge clk);
    din_s[k]   = d;
    start_s[k] = 1'b1;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    din_s[k]   = 7'($urandom);
    for (int c = 1; c <= eo + 1; c++) begin
      n_checks++;
      if (busy_o[k] !== (c <= eo)) begin
        n_fail++;
        $display("FAIL %s busy u%0d din=%b cycle %0d: got %b exp %b", tag, k, d, c, busy_o[k], (c <= eo));
      end
      n_checks++;
      if (done_o[k] !== (c == eo + 1)) begin
        n_fail++;
        $display("FAIL %s done u%0d din=%b cycle %0d: got %b exp %b", tag, k, d, c, done_o[k], (c == eo + 1));
      end
      if (c == eo + 1) begin
        n_checks++;
        if (res_o[k] !== er) begin
          n_fail++;
          $display("FAIL %s result u%0d din=%b: got %b exp %b", tag, k, d, res_o[k], er);
        end
        n_checks++;
        if (ops_o[k] !== 4'(eo)) begin
          n_fail++;
          $display("FAIL %s ops u%0d din=%b: got %0d exp %0d", tag, k, d, ops_o[k], eo);
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (done_o[k] !== 1'b0 || busy_o[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle u%0d din=%b: got busy=%b done=%b exp 0 0", tag, k, d, busy_o[k], done_o[k]);
    end
    $display("txn %s u%0d din=%b result=%b ops=%0d (model %b %0d)", tag, k, d, res_o[k], ops_o[k], er, eo);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b1;
      din_s[k]   = 7'h7f;
    end
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (busy_o[k] !== 1'b0 || done_o[k] !== 1'b0 || res_o[k] !== 1'b0 || ops_o[k] !== 4'd0) begin
          n_fail++;
          $display("FAIL reset u%0d edge %0d: got busy=%b done=%b result=%b ops=%0d exp all 0",
                   k, e, busy_o[k], done_o[k], res_o[k], ops_o[k]);
        end
      end
    end
    for (int k = 0; k < 3; k++) start_s[k] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_sweep();
    for (int d = 0; d < 8; d++) run_one(0, 7'(d), "sweep");
  endtask

  task automatic test_early_exit();
    run_one(1, 7'b110, "early");
    run_one(1, 7'b101, "early");
    run_one(1, 7'b111, "early");
  endtask

  task automatic test_ignore_start();
    int   cnt = 0;
    int   dc  = 0;
    logic r   = 1'b0;
    logic [3:0] o = '0;
    @(negedge clk);
    din_s[0]   = 7'b111;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    din_s[0] = 7'b000;
    for (int c = 1; c <= 6; c++) begin
      if (done_o[0] === 1'b1) begin
        cnt++;
        if (cnt == 1) begin
          dc = c;
          r  = res_o[0];
          o  = ops_o[0];
        end
      end
      start_s[0] = (c <= 2);
      @(posedge clk); #1;
    end
    start_s[0] = 1'b0;
    n_checks++;
    if (cnt != 1 || dc != 3) begin
      n_fail++;
      $display("FAIL ignore_start pulses: got %0d at cycle %0d exp 1 at cycle 3", cnt, dc);
    end
    n_checks++;
    if (r !== 1'b1 || o !== 4'd2) begin
      n_fail++;
      $display("FAIL ignore_start result: got %b ops %0d exp 1 ops 2", r, o);
    end
    $display("txn ignore_start result=%b ops=%0d pulses=%0d", r, o, cnt);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    din_s[0]   = 7'b111;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0 || res_o[0] !== 1'b0 || ops_o[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got busy=%b done=%b result=%b ops=%0d exp all 0",
               busy_o[0], done_o[0], res_o[0], ops_o[0]);
    end
    $display("txn reset_mid_run");
    run_one(0, 7'b011, "post_rst");
  endtask

  task automatic test_back_to_back();
    logic r1, r2;
    int   o1, o2;
    int   d1, d2;
    model(3, 0, 7'b111, r1, o1);
    model(3, 0, 7'b001, r2, o2);
    d1 = o1 + 1;
    d2 = d1 + o2 + 1;
    @(negedge clk);
    din_s[0]   = 7'b111;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    din_s[0] = 7'b001;
    for (int c = 1; c <= d2 + 1; c++) begin
      n_checks++;
      if (done_o[0] !== (c == d1 || c == d2)) begin
        n_fail++;
        $display("FAIL b2b done cycle %0d: got %b exp %b", c, done_o[0], (c == d1 || c == d2));
      end
      n_checks++;
      if (busy_o[0] !== (c < d2 && c != d1)) begin
        n_fail++;
        $display("FAIL b2b busy cycle %0d: got %b exp %b", c, busy_o[0], (c < d2 && c != d1));
      end
      if (c == d1 || c == d2) begin
        n_checks++;
        if (res_o[0] !== ((c == d1) ? r1 : r2) || ops_o[0] !== 4'((c == d1) ? o1 : o2)) begin
          n_fail++;
          $display("FAIL b2b result cycle %0d: got %b ops %0d exp %b ops %0d", c, res_o[0], ops_o[0],
                   (c == d1) ? r1 : r2, (c == d1) ? o1 : o2);
        end
      end
      if (c > d1) start_s[0] = 1'b0;
      @(posedge clk); #1;
    end
    $display("txn back_to_back results %b %b", r1, r2);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int k;
      logic [6:0] d;
      k = int'($urandom_range(0, 2));
      d = 7'($urandom) & 7'((1 << n_of(k)) - 1);
      run_one(k, d, "random");
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      din_s[k]   = '0;
    end
    test_reset();
    test_sweep();
    test_early_exit();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/and_reduce_sequencer.md
Name: and_reduce_sequencer

Overview:
Sequencer that time-shares one 2-input and_gate instance to compute the AND-reduction of an N-bit operand word, one bit per clock. It replaces a chain of N-1 gate instances with a single gate, an accumulator and a small FSM. It uses a start/busy/done handshake and is the controller that multi-input AND lab exercises drive instead of hand-wiring gate chains.

Parameters:
N, 3, operand width in bits (number of AND inputs); legal range 1..15.
EARLY_EXIT, 0, when 1, finish as soon as the accumulator becomes 0.
CNT_W, 4, width of the ops counter; must satisfy 2**CNT_W > N-1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request to begin a reduction; sampled only when busy=0.
din  input  N  operand word; captured on the accepted start edge.
busy  output  1  high while a reduction is in progress (state RUN).
done  output  1  one-cycle pulse: the result is valid and was just completed.
result  output  1  AND of all captured bits; held until the next accepted start.
ops  output  CNT_W  number of gate operations used by the last reduction.

Behaviour:
- Reset (rst=1 at an edge): state<=IDLE, busy=0, done=0, result=0, ops=0, and internal idx and operand register <=0. Reset has priority over every other event, including during RUN.
- Datapath: exactly one and_gate instance (port order out,a,b) with a=accumulator and b=opreg[idx]. No other AND logic may be used to compute result.
- FSM states:
  - IDLE: the idle state.
  - RUN: the reduction is in progress.
  - DONE: lasts exactly one cycle; done=1 and busy=0.
- Start acceptance: start is accepted at an edge when state is IDLE or DONE. On acceptance:
  - opreg<=din, acc<=din[0], idx<=1, ops<=0, state<=RUN.
  - If N==1, or EARLY_EXIT=1 and din[0]==0, state<=DONE instead of RUN.
- In RUN, at each edge:
  - acc<=gate output, idx<=idx+1, ops<=ops+1.
  - If idx==N-1, state<=DONE.
  - Else if EARLY_EXIT=1 and the gate output is 0, state<=DONE.
  - Else stay in RUN.
- result mirrors acc. It is 1 only if every consumed bit is 1.
- In DONE: if start=1, accept it (back-to-back operation, no idle gap); otherwise go to IDLE. done=0 in every state except DONE.
- Start while busy=1 is ignored. din changes during RUN have no effect.
- Latency with EARLY_EXIT=0: done is high in the Nth cycle after the accepted start edge, and ops=N-1.
- With early exit: ops = index of the first zero bit (0 if din[0]=0).
- ops never exceeds N-1, so no wrap-around is possible.
- Reset in the same cycle as start: reset wins and the start is lost.

Test Plan:
1. Reset: hold rst=1 for 2 edges with start=1 and din=3'b111 -> busy=0, done=0, result=0, ops=0, no done pulse.
2. N=3, EARLY_EXIT=0, sweep din 000..111 with a single start pulse each:
   - result=1 only for 111; ops=2 on every run.
   - done pulses exactly 3 cycles after each start edge, and busy=1 for 2 cycles.
3. N=3, EARLY_EXIT=1:
   - din=3'b110 -> done 1 cycle after start, ops=0, result=0.
   - din=3'b101 -> done at cycle 2, ops=1, result=0.
   - din=3'b111 -> done at cycle 3, ops=2, result=1.
4. Start din=3'b111, then pulse start with din=3'b000 during RUN -> ignored; result=1, ops=2, exactly one done pulse.
5. Start din=3'b111 and assert rst in the 2nd RUN cycle:
   - Next edge: IDLE, busy=0, result=0, no done.
   - A following start with din=3'b011 gives result=0, ops=2.
6. Back-to-back: hold start=1 through the DONE cycle, first din=3'b111 and second din=3'b001 -> results 1 then 0; done pulses 3 cycles apart; busy never low except during the DONE cycle.
